// File: rtl/soc_spram_arb_if.sv
// soc_spram_arb_if -- two-port request/acknowledge bus into the SPRAM arbiter.
//
// Parameter:
//   AW        word address width (14 = 64 KiB, 15 = 128 KiB)
// Signals (per port x in {a, b}):
//   x_addr    word address
//   x_wdata   write data
//   x_wmsk    byte write enables, bit n = byte n
//   x_we      1 = write, 0 = read
//   x_req     request, held high until x_ack
//   x_ack     single-cycle completion strobe
//   x_rdata   read data, valid only in the ack cycle of a read, 0 otherwise
// Modports:
//   master    requester side (drives req/addr/data, receives ack/rdata)
//   slave     arbiter side
interface soc_spram_arb_if #(
   parameter int AW = 14
);
   logic [AW-1:0] a_addr;
   logic [31:0]   a_wdata;
   logic [3:0]    a_wmsk;
   logic          a_we;
   logic          a_req;
   logic          a_ack;
   logic [31:0]   a_rdata;

   logic [AW-1:0] b_addr;
   logic [31:0]   b_wdata;
   logic [3:0]    b_wmsk;
   logic          b_we;
   logic          b_req;
   logic          b_ack;
   logic [31:0]   b_rdata;

   modport master (
      output a_addr, a_wdata, a_wmsk, a_we, a_req,
      input  a_ack, a_rdata,
      output b_addr, b_wdata, b_wmsk, b_we, b_req,
      input  b_ack, b_rdata
   );

   modport slave (
      input  a_addr, a_wdata, a_wmsk, a_we, a_req,
      output a_ack, a_rdata,
      input  b_addr, b_wdata, b_wmsk, b_we, b_req,
      output b_ack, b_rdata
   );
endinterface

// File: rtl/soc_spram_arb.sv
// soc_spram_arb -- two-port arbiter in front of 16Kx16 single-port RAM pairs.
//
// Parameters:
//   AW          word address width, 14 (one SPRAM pair) or 15 (two pairs)
//   STARVE_MAX  consecutive contended port-A grants before port B is forced
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   bus         soc_spram_arb_if.slave, ports A and B
//   dbg_state   current FSM state (0 = IDLE, 1 = ACK)
// Configuration macro:
//   SOC_SPRAM_ARB_RR_EN  when defined, simultaneous requests alternate
//                        round-robin instead of fixed A priority with a
//                        starvation counter for B.
//
// Handshake: a port raises x_req with its command stable and holds both until
// x_ack. A port that requests while not being acked is granted combinationally
// and issued to the RAM in that cycle; x_ack pulses for exactly the following
// cycle, carrying read data on x_rdata. A port is never granted in its own ack
// cycle, so the other port can use the RAM then and contended traffic
// alternates at one access per cycle.
module soc_spram_arb #(
   parameter int AW         = 14,
   parameter int STARVE_MAX = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   soc_spram_arb_if.slave       bus,
   output logic                 dbg_state
);

   localparam int   NPAIR  = 1 << (AW - 14);
   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

   state_t        state, state_next;
   logic          owner, owner_next;       // port being acked in ACK
   logic          ack_we, ack_we_next;     // acked access was a write
   logic          ack_pair, ack_pair_next; // pair the acked access went to

`ifdef SOC_SPRAM_ARB_RR_EN
   logic          rr_ptr, rr_ptr_next;     // port that wins the next tie
`else
   localparam int CW = $clog2(STARVE_MAX + 1);
   logic [CW-1:0] starve_cnt, starve_cnt_next;
`endif

   logic          a_elig, b_elig, gnt_a, gnt_b, issue;
   logic [AW-1:0] gnt_addr;
   logic [31:0]   gnt_wdata;
   logic [3:0]    gnt_wmsk;
   logic          gnt_we;
   logic          pair_sel;
   logic [31:0]   sel_dout;
   logic [31:0]   pair_dout [NPAIR];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         owner      <= PORT_A;
         ack_we     <= 1'b0;
         ack_pair   <= 1'b0;
`ifdef SOC_SPRAM_ARB_RR_EN
         rr_ptr     <= PORT_A;
`else
         starve_cnt <= '0;
`endif
      end else begin
         state      <= state_next;
         owner      <= owner_next;
         ack_we     <= ack_we_next;
         ack_pair   <= ack_pair_next;
`ifdef SOC_SPRAM_ARB_RR_EN
         rr_ptr     <= rr_ptr_next;
`else
         starve_cnt <= starve_cnt_next;
`endif
      end
   end

   always_comb begin
      // rst gates eligibility so no RAM write enable can fire during reset.
      a_elig = bus.a_req && !rst && !(state == ACK && owner == PORT_A);
      b_elig = bus.b_req && !rst && !(state == ACK && owner == PORT_B);
      gnt_a  = 1'b0;
      gnt_b  = 1'b0;
      if (a_elig && b_elig) begin
`ifdef SOC_SPRAM_ARB_RR_EN
         gnt_b = rr_ptr;
`else
         gnt_b = (starve_cnt >= CW'(STARVE_MAX));
`endif
         gnt_a = !gnt_b;
      end else begin
         gnt_a = a_elig;
         gnt_b = b_elig;
      end
      issue     = gnt_a || gnt_b;

      gnt_addr  = gnt_b ? bus.b_addr  : bus.a_addr;
      gnt_wdata = gnt_b ? bus.b_wdata : bus.a_wdata;
      gnt_wmsk  = gnt_b ? bus.b_wmsk  : bus.a_wmsk;
      gnt_we    = gnt_b ? bus.b_we    : bus.a_we;
      // Top address bit picks the pair only in the two-pair build.
      pair_sel  = (AW > 14) ? gnt_addr[AW-1] : 1'b0;

      state_next    = issue ? ACK : IDLE;
      owner_next    = issue ? gnt_b : owner;
      ack_we_next   = issue ? gnt_we : ack_we;
      ack_pair_next = issue ? pair_sel : ack_pair;

`ifdef SOC_SPRAM_ARB_RR_EN
      rr_ptr_next = rr_ptr;
      if (a_elig && b_elig) rr_ptr_next = !gnt_b;  // point at the loser
`else
      starve_cnt_next = starve_cnt;
      if (!bus.b_req || gnt_b)
         starve_cnt_next = '0;
      else if (gnt_a && starve_cnt < CW'(STARVE_MAX))
         starve_cnt_next = starve_cnt + 1'b1;
`endif

      sel_dout = pair_dout[0];
      if (NPAIR > 1 && ack_pair) sel_dout = pair_dout[NPAIR-1];

      bus.a_ack   = (state == ACK) && (owner == PORT_A);
      bus.b_ack   = (state == ACK) && (owner == PORT_B);
      bus.a_rdata = (bus.a_ack && !ack_we) ? sel_dout : 32'h0;
      bus.b_rdata = (bus.b_ack && !ack_we) ? sel_dout : 32'h0;
      dbg_state   = (state == ACK);
   end

   // Each pair is two 16-bit RAMs side by side; each RAM has a 4-bit nibble
   // write mask, so every byte enable drives two adjacent nibble enables.
   // Only one access reaches the RAMs per cycle, so read-before-write
   // ordering is inherent in the single-port array.
   for (genvar p = 0; p < NPAIR; p++) begin : g_pair
      logic cs;
      assign cs = issue && (pair_sel == 1'(p));

      for (genvar h = 0; h < 2; h++) begin : g_half
         logic [15:0] mem [0:16383];
         logic [15:0] dout;
         logic [3:0]  nib_msk;

         assign nib_msk = {gnt_wmsk[2*h+1], gnt_wmsk[2*h+1],
                           gnt_wmsk[2*h],   gnt_wmsk[2*h]};

         always_ff @(posedge clk) begin
            if (cs) begin
               if (gnt_we) begin
                  for (int n = 0; n < 4; n++) begin
                     if (nib_msk[n])
                        mem[gnt_addr[13:0]][4*n +: 4] <= gnt_wdata[16*h + 4*n +: 4];
                  end
               end else begin
                  dout <= mem[gnt_addr[13:0]];
               end
            end
         end
      end

      assign pair_dout[p] = {g_half[1].dout, g_half[0].dout};
   end

endmodule
